pe_circular_buffer: RTL and testbench
=====================================

// Module: pe_circular_buffer
// PURPOSE
//  Parameterised ring-buffer FIFO for the Eyeriss PE datapath (ifmap, filter, psum and output queues).
//  - Accepts W_PARAM words per write beat.
//  - Presents the R_PARAM oldest words, show-ahead, for a single-cycle pop.
//  - Provides ready/valid flow control plus full/empty status.
// PARAMETERS
//  DATA_WIDTH   16  bits per stored word (ifmap queue instantiates 18: {start,end,data})
//  BUFFER_SIZE  32  capacity in words; any value >= max(W_PARAM,R_PARAM), need not be a power of 2
//  W_PARAM      1   words pushed per accepted write
//  R_PARAM      1   words popped per accepted read
// PORTS
//  clk       in   1                     single clock, rising edge
//  rst       in   1                     asynchronous, active-high reset
//  write_en  in   1                     push request
//  read_en   in   1                     pop request; consumer must drive it, never leave it floating
//  inp       in   DATA_WIDTH*W_PARAM    write data; word i = inp[i*DATA_WIDTH +: DATA_WIDTH], word 0 oldest
//  full      out  1                     count == BUFFER_SIZE
//  empty     out  1                     count == 0
//  ready     out  1                     free space >= W_PARAM (BUFFER_SIZE-count >= W_PARAM)
//  valid     out  1                     count >= R_PARAM
//  data_out  out  DATA_WIDTH*R_PARAM    R_PARAM oldest words, word 0 = oldest; all zero when valid==0
// BEHAVIOUR
//  - State: storage mem[0..BUFFER_SIZE-1], wr_ptr, rd_ptr, count (width $clog2(BUFFER_SIZE+1)).
//  - Reset (async, rst=1): wr_ptr=rd_ptr=count=0 immediately.
//    - Outputs during reset: empty=1, full=0, ready=1, valid=0, data_out=0.
//    - mem contents are not cleared.
//    - Reset mid-operation discards all queued data; no partial beat survives.
//  - Write accepted on a rising edge iff write_en && ready.
//    - mem[(wr_ptr+i) mod BUFFER_SIZE] <= word i, for i = 0..W_PARAM-1.
//    - wr_ptr advances by W_PARAM modulo BUFFER_SIZE.
//    - write_en while !ready is silently dropped; no state change.
//  - Read accepted on a rising edge iff read_en && valid.
//    - rd_ptr advances by R_PARAM modulo BUFFER_SIZE.
//    - The consumer samples data_out in that same cycle (zero-latency show-ahead).
//    - read_en while !valid is ignored.
//  - data_out is combinational from mem and rd_ptr: word j = mem[(rd_ptr+j) mod BUFFER_SIZE].
//  - Write latency: a word written at edge N is visible on data_out after edge N, i.e. in cycle N+1.
//  - Simultaneous accepted read and write in one cycle: count <= count + W_PARAM - R_PARAM.
//    - ready/valid are computed from the registered count only; no same-cycle bypass.
//    - When full, a write is refused even if a read occurs in the same cycle.
//  - Wrap-around: pointer arithmetic wraps at BUFFER_SIZE, not 2^n; multi-word beats may straddle the wrap.
//  - Flags (full, empty, ready, valid) are combinational decodes of count and glitch-free relative to clk.
// CONFIGURATION
//  - Macro PE_CIRC_BUF_ERR_FLAGS_EN.
//  - Defined: adds outputs overflow (1b) and underflow (1b), each reset to 0.
//    - overflow sets sticky on any edge with write_en && !ready.
//    - underflow sets sticky on any edge with read_en && !valid.
//    - Both clear only on rst.
//  - Undefined: ports absent; dropped requests leave no trace. Datapath identical either way.
// STRUCTURE
//  - Shared package pe_buf_pkg holds:
//    - default constants DATA_WIDTH_DEF=16, BUFFER_SIZE_DEF=32;
//    - IFMAP_TAG_W=2 (start/end tag bits prepended to ifmap words);
//    - function ptr_add(ptr,inc,size) implementing modular pointer advance.
//  - No sub-module: the single flat module holds mem, pointers, count and flag decode.
// TESTING
//  - Reset/idle: assert rst, release
//    -> empty=1, full=0, ready=1, valid=0, data_out=0; read_en pulses change nothing.
//  - Show-ahead order (W=R=1): push -129, 3, 41 on consecutive cycles
//    -> valid=1 in the cycle after the first push, data_out=16'hFF7F;
//    -> three pops return 16'hFF7F, 3, 41, then valid=0, empty=1.
//  - Full boundary (BUFFER_SIZE=32): push 32 words 0..31 -> full=1, ready=0.
//    - A 33rd write_en is dropped; draining yields 0..31 exactly, with no value 32.
//  - Wrap and concurrency: keep 5 words queued, then push and pop together for 40 cycles
//    -> count stays 5; output sequence is strictly increasing across the pointer wrap.
//  - Tagged 18-bit ifmap: push {1,0,14}, {0,0,39}, {0,1,-80}
//    -> data_out = 18'h2000E, 18'h00027, 18'h1FFB0 in order.
//  - Multi-word (W=2,R=3,SIZE=7): after pushes {1,2}, {3,4} -> valid=1, data_out={3,2,1} (word 0 = 1).
//    - After the pop: count=1, valid=0.
//    - With PE_CIRC_BUF_ERR_FLAGS_EN, a read_en now sets underflow=1 and holds it until rst.

Source files
------------

// File: rtl/pe_buf_pkg.sv
// ----------------------------------------------------------------------------
// pe_buf_pkg
// Shared constants and helpers for the Eyeriss PE queue buffers.
//   DATA_WIDTH_DEF  : default stored word width
//   BUFFER_SIZE_DEF : default capacity in words
//   IFMAP_TAG_W     : {start,end} tag bits prepended to ifmap words
//   ptr_add()       : modular pointer advance for non power-of-2 rings
// ----------------------------------------------------------------------------
package pe_buf_pkg;

    localparam int unsigned DATA_WIDTH_DEF  = 16;
    localparam int unsigned BUFFER_SIZE_DEF = 32;
    localparam int unsigned IFMAP_TAG_W     = 2;

    // Advance ptr by inc, wrapping at size. Callers guarantee ptr < size and
    // inc <= size, so one conditional subtract is enough and no divider is
    // needed for sizes that are not a power of two.
    function automatic int unsigned ptr_add(input int unsigned ptr,
                                            input int unsigned inc,
                                            input int unsigned size);
        int unsigned sum;
        sum = ptr + inc;
        return (sum >= size) ? (sum - size) : sum;
    endfunction

endpackage

// File: rtl/pe_circular_buffer.sv
// ----------------------------------------------------------------------------
// pe_circular_buffer
// Ring-buffer FIFO for the PE datapath queues. Accepts W_PARAM words per
// write beat and presents the R_PARAM oldest words show-ahead so the consumer
// pops them in the same cycle it sees them.
//
// Ports
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   write_en  : push request, accepted when ready
//   read_en   : pop request, accepted when valid
//   inp       : W_PARAM words, word 0 (oldest) in the LSBs
//   full      : count == BUFFER_SIZE
//   empty     : count == 0
//   ready     : room for a full write beat
//   valid     : at least R_PARAM words queued
//   overflow  : sticky, write_en seen while !ready   (PE_CIRC_BUF_ERR_FLAGS_EN)
//   underflow : sticky, read_en seen while !valid    (PE_CIRC_BUF_ERR_FLAGS_EN)
//   data_out  : R_PARAM oldest words, word 0 in the LSBs; zero when !valid
//
// Build option: define PE_CIRC_BUF_ERR_FLAGS_EN to add the sticky
// overflow/underflow outputs. The datapath is identical either way.
// ----------------------------------------------------------------------------
module pe_circular_buffer
    import pe_buf_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int unsigned BUFFER_SIZE = BUFFER_SIZE_DEF,
    parameter int unsigned W_PARAM     = 1,
    parameter int unsigned R_PARAM     = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          write_en,
    input  logic                          read_en,
    input  logic [DATA_WIDTH*W_PARAM-1:0] inp,
    output logic                          full,
    output logic                          empty,
    output logic                          ready,
    output logic                          valid,
`ifdef PE_CIRC_BUF_ERR_FLAGS_EN
    output logic                          overflow,
    output logic                          underflow,
`endif
    output logic [DATA_WIDTH*R_PARAM-1:0] data_out
);

    localparam int unsigned PW = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;
    localparam int unsigned CW = $clog2(BUFFER_SIZE + 1);

    logic [DATA_WIDTH-1:0] mem_q [BUFFER_SIZE];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [PW-1:0]         wr_idx [W_PARAM];
    logic [PW-1:0]         rd_idx [R_PARAM];
    logic                  wr_fire;
    logic                  rd_fire;

    // Flags decode the registered count only, so a pop in the same cycle
    // never makes room for a write (no bypass path).
    assign full    = (count_q == CW'(BUFFER_SIZE));
    assign empty   = (count_q == '0);
    assign ready   = (count_q <= CW'(BUFFER_SIZE - W_PARAM));
    assign valid   = (count_q >= CW'(R_PARAM));
    assign wr_fire = write_en && ready;
    assign rd_fire = read_en && valid;

    // Per-word ring slots for this beat; multi-word beats may straddle the wrap.
    always_comb begin
        for (int unsigned i = 0; i < W_PARAM; i++) begin
            wr_idx[i] = PW'(ptr_add(32'(wr_ptr_q), i, BUFFER_SIZE));
        end
        for (int unsigned j = 0; j < R_PARAM; j++) begin
            rd_idx[j] = PW'(ptr_add(32'(rd_ptr_q), j, BUFFER_SIZE));
        end
    end

    always_comb begin
        wr_ptr_d = wr_fire ? PW'(ptr_add(32'(wr_ptr_q), W_PARAM, BUFFER_SIZE)) : wr_ptr_q;
        rd_ptr_d = rd_fire ? PW'(ptr_add(32'(rd_ptr_q), R_PARAM, BUFFER_SIZE)) : rd_ptr_q;
        count_d  = count_q + (wr_fire ? CW'(W_PARAM) : '0)
                           - (rd_fire ? CW'(R_PARAM) : '0);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage has no reset; pointers and count define which slots hold
    // live data, so clearing the array would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (wr_fire && !rst) begin
            for (int unsigned i = 0; i < W_PARAM; i++) begin
                mem_q[wr_idx[i]] <= inp[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // NOTE: data_out gets a default before the conditional fill so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        data_out = '0;
        if (valid) begin
            for (int unsigned j = 0; j < R_PARAM; j++) begin
                data_out[j*DATA_WIDTH +: DATA_WIDTH] = mem_q[rd_idx[j]];
            end
        end
    end

`ifdef PE_CIRC_BUF_ERR_FLAGS_EN
    logic overflow_q;
    logic underflow_q;

    // Sticky error capture of refused requests; only reset clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (write_en && !ready) overflow_q  <= 1'b1;
            if (read_en && !valid)  underflow_q <= 1'b1;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_pe_circular_buffer.sv
// ----------------------------------------------------------------------------
// tb_pe_circular_buffer
// Self-checking bench for pe_circular_buffer. Three instances share clk/rst:
//   u_a : 16-bit, 32 words, W=R=1 (main queue)
//   u_t : 18-bit tagged ifmap queue, 32 words, W=R=1
//   u_m : 16-bit, 7 words, W=2, R=3 (multi-word, odd size)
// Expected data comes from per-instance scoreboard queues filled as stimulus
// is driven and drained as the DUT presents words.
// ----------------------------------------------------------------------------
module tb_pe_circular_buffer;
    import pe_buf_pkg::*;

    localparam int unsigned T_DW = 16 + IFMAP_TAG_W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Instance A
    logic        a_we, a_re, a_full, a_empty, a_ready, a_valid;
    logic [15:0] a_inp, a_dout;
    // Instance T
    logic            t_we, t_re, t_full, t_empty, t_ready, t_valid;
    logic [T_DW-1:0] t_inp, t_dout;
    // Instance M
    logic        m_we, m_re, m_full, m_empty, m_ready, m_valid;
    logic [31:0] m_inp;
    logic [47:0] m_dout;
`ifdef PE_CIRC_BUF_ERR_FLAGS_EN
    logic a_ovf, a_unf, t_ovf, t_unf, m_ovf, m_unf;
`endif

    logic [15:0]     sb_a [$];
    logic [T_DW-1:0] sb_t [$];
    logic [15:0]     sb_m [$];

    pe_circular_buffer #(.DATA_WIDTH(16), .BUFFER_SIZE(32), .W_PARAM(1), .R_PARAM(1)) u_a (
        .clk(clk), .rst(rst), .write_en(a_we), .read_en(a_re), .inp(a_inp),
        .full(a_full), .empty(a_empty), .ready(a_ready), .valid(a_valid),
`ifdef PE_CIRC_BUF_ERR_FLAGS_EN
        .overflow(a_ovf), .underflow(a_unf),
`endif
        .data_out(a_dout)
    );

    pe_circular_buffer #(.DATA_WIDTH(T_DW), .BUFFER_SIZE(32), .W_PARAM(1), .R_PARAM(1)) u_t (
        .clk(clk), .rst(rst), .write_en(t_we), .read_en(t_re), .inp(t_inp),
        .full(t_full), .empty(t_empty), .ready(t_ready), .valid(t_valid),
`ifdef PE_CIRC_BUF_ERR_FLAGS_EN
        .overflow(t_ovf), .underflow(t_unf),
`endif
        .data_out(t_dout)
    );

    pe_circular_buffer #(.DATA_WIDTH(16), .BUFFER_SIZE(7), .W_PARAM(2), .R_PARAM(3)) u_m (
        .clk(clk), .rst(rst), .write_en(m_we), .read_en(m_re), .inp(m_inp),
        .full(m_full), .empty(m_empty), .ready(m_ready), .valid(m_valid),
`ifdef PE_CIRC_BUF_ERR_FLAGS_EN
        .overflow(m_ovf), .underflow(m_unf),
`endif
        .data_out(m_dout)
    );

    // Advance to just after the next rising edge; all driving and sampling
    // happens there, away from the edge itself.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        a_we = 1'b0; a_re = 1'b0; a_inp = '0;
        t_we = 1'b0; t_re = 1'b0; t_inp = '0;
        m_we = 1'b0; m_re = 1'b0; m_inp = '0;
        #3;
        n_checks++;
        if ({a_empty, a_full, a_ready, a_valid} !== 4'b1010 || a_dout !== 16'h0) begin
            n_errors++;
            $display("FAIL reset_a: flags e/f/r/v=%b dout=%h, want 1010 dout=0000",
                     {a_empty, a_full, a_ready, a_valid}, a_dout);
        end
        n_checks++;
        if ({t_empty, t_full, t_ready, t_valid, m_empty, m_full, m_ready, m_valid} !== 8'b1010_1010
            || t_dout !== '0 || m_dout !== '0) begin
            n_errors++;
            $display("FAIL reset_tm: flags=%b t_dout=%h m_dout=%h, want 10101010 and zeros",
                     {t_empty, t_full, t_ready, t_valid, m_empty, m_full, m_ready, m_valid},
                     t_dout, m_dout);
        end
`ifdef PE_CIRC_BUF_ERR_FLAGS_EN
        n_checks++;
        if ({a_ovf, a_unf, m_ovf, m_unf} !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset_errflags: got %b want 0000", {a_ovf, a_unf, m_ovf, m_unf});
        end
`endif
        tick();
        tick();
        rst = 1'b0;
        a_re = 1'b1;
        tick(); tick(); tick();
        a_re = 1'b0;
        n_checks++;
        if ({a_empty, a_full, a_ready, a_valid} !== 4'b1010 || a_dout !== 16'h0) begin
            n_errors++;
            $display("FAIL idle_read: flags e/f/r/v=%b dout=%h, want 1010 dout=0000",
                     {a_empty, a_full, a_ready, a_valid}, a_dout);
        end
`ifdef PE_CIRC_BUF_ERR_FLAGS_EN
        n_checks++;
        if (a_unf !== 1'b1 || a_ovf !== 1'b0) begin
            n_errors++;
            $display("FAIL idle_underflow: ovf=%b unf=%b want ovf=0 unf=1", a_ovf, a_unf);
        end
`endif
    endtask

    task automatic test_show_ahead();
        logic [15:0] vals [3];
        logic [15:0] exp;
        vals[0] = 16'(-129); vals[1] = 16'd3; vals[2] = 16'd41;
        for (int i = 0; i < 3; i++) begin
            a_we = 1'b1; a_inp = vals[i]; sb_a.push_back(vals[i]);
            tick();
            if (i == 0) begin
                n_checks++;
                if (a_valid !== 1'b1 || a_dout !== 16'hFF7F) begin
                    n_errors++;
                    $display("FAIL show_first: valid=%b dout=%h want valid=1 dout=ff7f", a_valid, a_dout);
                end
            end
        end
        a_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp = sb_a.pop_front();
            n_checks++;
            if (a_valid !== 1'b1 || a_dout !== exp) begin
                n_errors++;
                $display("FAIL show_pop%0d: valid=%b dout=%h want valid=1 dout=%h", i, a_valid, a_dout, exp);
            end
            a_re = 1'b1;
            tick();
            a_re = 1'b0;
        end
        n_checks++;
        if (a_valid !== 1'b0 || a_empty !== 1'b1) begin
            n_errors++;
            $display("FAIL show_drained: valid=%b empty=%b want valid=0 empty=1", a_valid, a_empty);
        end
    endtask

    task automatic test_full_boundary();
        logic [15:0] exp;
        for (int i = 0; i < 32; i++) begin
            a_we = 1'b1; a_inp = 16'(i); sb_a.push_back(16'(i));
            tick();
        end
        a_we = 1'b0;
        n_checks++;
        if (a_full !== 1'b1 || a_ready !== 1'b0 || a_empty !== 1'b0) begin
            n_errors++;
            $display("FAIL full_flags: full=%b ready=%b empty=%b want 1 0 0", a_full, a_ready, a_empty);
        end
        a_we = 1'b1; a_inp = 16'd32;   // refused: must not be stored
        tick();
        a_we = 1'b0;
        n_checks++;
        if (a_full !== 1'b1 || a_dout !== 16'd0) begin
            n_errors++;
            $display("FAIL full_drop: full=%b dout=%h want full=1 dout=0000", a_full, a_dout);
        end
`ifdef PE_CIRC_BUF_ERR_FLAGS_EN
        n_checks++;
        if (a_ovf !== 1'b1) begin
            n_errors++;
            $display("FAIL full_overflow: got %b want 1", a_ovf);
        end
`endif
        for (int i = 0; i < 32; i++) begin
            exp = sb_a.pop_front();
            n_checks++;
            if (a_valid !== 1'b1 || a_dout !== exp) begin
                n_errors++;
                $display("FAIL full_drain%0d: valid=%b dout=%h want valid=1 dout=%h", i, a_valid, a_dout, exp);
            end
            a_re = 1'b1;
            tick();
            a_re = 1'b0;
        end
        n_checks++;
        if (a_empty !== 1'b1 || a_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL full_after_drain: empty=%b valid=%b want empty=1 valid=0", a_empty, a_valid);
        end
    endtask

    task automatic test_wrap_concurrency();
        logic [15:0] exp;
        logic [15:0] last;
        for (int i = 0; i < 5; i++) begin
            a_we = 1'b1; a_inp = 16'(100 + i); sb_a.push_back(16'(100 + i));
            tick();
        end
        last = 16'd99;
        for (int k = 0; k < 40; k++) begin
            exp = sb_a.pop_front();
            n_checks++;
            if (a_dout !== exp || a_dout <= last || a_valid !== 1'b1 || a_ready !== 1'b1) begin
                n_errors++;
                $display("FAIL wrap_cycle%0d: dout=%h last=%h valid=%b ready=%b want dout=%h v=1 r=1",
                         k, a_dout, last, a_valid, a_ready, exp);
            end
            last = a_dout;
            a_we = 1'b1; a_re = 1'b1; a_inp = 16'(105 + k); sb_a.push_back(16'(105 + k));
            tick();
        end
        a_we = 1'b0; a_re = 1'b0;
        // Exactly five words must remain.
        for (int i = 0; i < 5; i++) begin
            exp = sb_a.pop_front();
            n_checks++;
            if (a_valid !== 1'b1 || a_dout !== exp) begin
                n_errors++;
                $display("FAIL wrap_tail%0d: valid=%b dout=%h want valid=1 dout=%h", i, a_valid, a_dout, exp);
            end
            a_re = 1'b1;
            tick();
            a_re = 1'b0;
        end
        n_checks++;
        if (a_empty !== 1'b1) begin
            n_errors++;
            $display("FAIL wrap_count: empty=%b want 1 after five pops", a_empty);
        end
    endtask

    task automatic test_ifmap_tagged();
        logic [T_DW-1:0] vals [3];
        logic [T_DW-1:0] cst  [3];
        logic [T_DW-1:0] exp;
        vals[0] = {1'b1, 1'b0, 16'd14};
        vals[1] = {1'b0, 1'b0, 16'd39};
        vals[2] = {1'b0, 1'b1, 16'(-80)};
        cst[0] = 18'h2000E; cst[1] = 18'h00027; cst[2] = 18'h1FFB0;
        for (int i = 0; i < 3; i++) begin
            t_we = 1'b1; t_inp = vals[i]; sb_t.push_back(vals[i]);
            tick();
        end
        t_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp = sb_t.pop_front();
            n_checks++;
            if (t_valid !== 1'b1 || t_dout !== exp || t_dout !== cst[i]) begin
                n_errors++;
                $display("FAIL ifmap_pop%0d: valid=%b dout=%h want valid=1 dout=%h", i, t_valid, t_dout, cst[i]);
            end
            t_re = 1'b1;
            tick();
            t_re = 1'b0;
        end
        n_checks++;
        if (t_empty !== 1'b1) begin
            n_errors++;
            $display("FAIL ifmap_empty: got %b want 1", t_empty);
        end
    endtask

    task automatic test_multi_word();
        logic [47:0] exp;
        // Beats {1,2} and {3,4}; word 0 of each beat is the older one.
        m_we = 1'b1; m_inp = {16'd2, 16'd1}; sb_m.push_back(16'd1); sb_m.push_back(16'd2);
        tick();
        n_checks++;
        if (m_valid !== 1'b0 || m_dout !== 48'h0) begin
            n_errors++;
            $display("FAIL multi_two_words: valid=%b dout=%h want valid=0 dout=0", m_valid, m_dout);
        end
        m_inp = {16'd4, 16'd3}; sb_m.push_back(16'd3); sb_m.push_back(16'd4);
        tick();
        m_we = 1'b0;
        exp = {sb_m[2], sb_m[1], sb_m[0]};
        n_checks++;
        if (m_valid !== 1'b1 || m_dout !== exp || m_dout !== {16'd3, 16'd2, 16'd1}) begin
            n_errors++;
            $display("FAIL multi_show: valid=%b dout=%h want valid=1 dout=%h", m_valid, m_dout, exp);
        end
        m_re = 1'b1;
        tick();
        m_re = 1'b0;
        void'(sb_m.pop_front()); void'(sb_m.pop_front()); void'(sb_m.pop_front());
        n_checks++;
        if (m_valid !== 1'b0 || m_empty !== 1'b0 || m_dout !== 48'h0) begin
            n_errors++;
            $display("FAIL multi_after_pop: valid=%b empty=%b dout=%h want 0 0 0", m_valid, m_empty, m_dout);
        end
`ifdef PE_CIRC_BUF_ERR_FLAGS_EN
        m_re = 1'b1;
        tick();
        m_re = 1'b0;
        tick(); tick();
        n_checks++;
        if (m_unf !== 1'b1) begin
            n_errors++;
            $display("FAIL multi_underflow: got %b want 1", m_unf);
        end
`endif
        // Fill to 7 words; beat {7,8} straddles the wrap at slot 6.
        for (int i = 0; i < 3; i++) begin
            m_we = 1'b1;
            m_inp = {16'(6 + 2*i), 16'(5 + 2*i)};
            sb_m.push_back(16'(5 + 2*i)); sb_m.push_back(16'(6 + 2*i));
            tick();
        end
        n_checks++;
        if (m_full !== 1'b1 || m_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL multi_full: full=%b ready=%b want 1 0", m_full, m_ready);
        end
        m_inp = {16'd12, 16'd11};   // refused
        tick();
        m_we = 1'b0;
        for (int i = 0; i < 2; i++) begin
            exp = {sb_m[2], sb_m[1], sb_m[0]};
            n_checks++;
            if (m_valid !== 1'b1 || m_dout !== exp) begin
                n_errors++;
                $display("FAIL multi_pop%0d: valid=%b dout=%h want valid=1 dout=%h", i, m_valid, m_dout, exp);
            end
            m_re = 1'b1;
            tick();
            m_re = 1'b0;
            void'(sb_m.pop_front()); void'(sb_m.pop_front()); void'(sb_m.pop_front());
        end
        n_checks++;
        if (m_valid !== 1'b0 || m_empty !== 1'b0 || m_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL multi_residue: valid=%b empty=%b ready=%b want 0 0 1", m_valid, m_empty, m_ready);
        end
    endtask

    task automatic test_reset_mid_op();
        for (int i = 0; i < 3; i++) begin
            a_we = 1'b1; a_inp = 16'(200 + i);
            tick();
        end
        a_we = 1'b0;
        #2;
        rst = 1'b1;   // asserted mid-cycle: must act without a clock edge
        #1;
        sb_a.delete(); sb_m.delete();
        n_checks++;
        if ({a_empty, a_full, a_ready, a_valid} !== 4'b1010 || a_dout !== 16'h0 || m_empty !== 1'b1) begin
            n_errors++;
            $display("FAIL midreset_async: a flags=%b dout=%h m_empty=%b want 1010 0000 1",
                     {a_empty, a_full, a_ready, a_valid}, a_dout, m_empty);
        end
`ifdef PE_CIRC_BUF_ERR_FLAGS_EN
        n_checks++;
        if ({a_ovf, a_unf, m_ovf, m_unf} !== 4'b0000) begin
            n_errors++;
            $display("FAIL midreset_errflags: got %b want 0000", {a_ovf, a_unf, m_ovf, m_unf});
        end
`endif
        tick();
        rst = 1'b0;
        tick();
        n_checks++;
        if (a_valid !== 1'b0 || a_empty !== 1'b1 || m_valid !== 1'b0 || m_empty !== 1'b1) begin
            n_errors++;
            $display("FAIL midreset_after: a_valid=%b a_empty=%b m_valid=%b m_empty=%b want 0 1 0 1",
                     a_valid, a_empty, m_valid, m_empty);
        end
    endtask

    initial begin
        test_reset();
        test_show_ahead();
        test_full_boundary();
        test_wrap_concurrency();
        test_ifmap_tagged();
        test_multi_word();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
